// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle RV32 controller and its datapath.
// The master side (controller) drives the control and debug signals; the slave side (datapath) drives the instruction fields and Zero.
interface multicycle_controller_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       Zero;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       RegWrite;
    logic [2:0] ALUControl;
    logic [1:0] ImmSrc;
    logic [3:0] state;

    modport master (
        input  op, funct3, funct7b5, Zero,
        output PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ALUControl, ImmSrc, state
    );

    modport slave (
        output op, funct3, funct7b5, Zero,
        input  PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
               RegWrite, ALUControl, ImmSrc, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Main control FSM with ALU and immediate decoders for the multi-cycle RV32 core.
// Moore control outputs; only PCWrite also looks at Zero, for the beq decision.
module multicycle_controller #(
    parameter logic [2:0] ALU_ADD = 3'b000,
    parameter logic [2:0] ALU_SUB = 3'b001,
    parameter logic [2:0] ALU_AND = 3'b111,
    parameter logic [2:0] ALU_OR  = 3'b011,
    parameter logic [2:0] ALU_SLT = 3'b101
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master bus
);
    localparam logic [3:0] S_FETCH    = 4'd0;
    localparam logic [3:0] S_DECODE   = 4'd1;
    localparam logic [3:0] S_MEMADR   = 4'd2;
    localparam logic [3:0] S_MEMREAD  = 4'd3;
    localparam logic [3:0] S_MEMWB    = 4'd4;
    localparam logic [3:0] S_MEMWRITE = 4'd5;
    localparam logic [3:0] S_EXECR    = 4'd6;
    localparam logic [3:0] S_EXECI    = 4'd7;
    localparam logic [3:0] S_ALUWB    = 4'd8;
    localparam logic [3:0] S_BEQ      = 4'd9;
    localparam logic [3:0] S_JAL      = 4'd10;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    logic [3:0] r_state;
    logic [3:0] w_next;
    logic       w_pc_update;
    logic       w_branch;
    logic [1:0] w_alu_op;
    logic       w_ir_write;
    logic       w_mem_write;
    logic       w_reg_write;
    logic       w_adr_src;
    logic [1:0] w_result_src;
    logic [1:0] w_src_a;
    logic [1:0] w_src_b;
    logic [2:0] w_alu_control;
    logic [1:0] w_imm_src;

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_FETCH;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (bus.op)
                    OP_LW, OP_SW: w_next = S_MEMADR;
                    OP_R:         w_next = S_EXECR;
                    OP_I:         w_next = S_EXECI;
                    OP_BEQ:       w_next = S_BEQ;
                    OP_JAL:       w_next = S_JAL;
                    default:      w_next = S_FETCH;
                endcase
            end
            S_MEMADR:                     w_next = (bus.op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:                    w_next = S_MEMWB;
            S_EXECR, S_EXECI, S_JAL:      w_next = S_ALUWB;
            default:                      w_next = S_FETCH;
        endcase
    end

    always_comb begin
        w_pc_update  = 1'b0;
        w_branch     = 1'b0;
        w_alu_op     = 2'b00;
        w_ir_write   = 1'b0;
        w_mem_write  = 1'b0;
        w_reg_write  = 1'b0;
        w_adr_src    = 1'b0;
        w_result_src = 2'b00;
        w_src_a      = 2'b00;
        w_src_b      = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_ir_write = 1'b1; w_src_b = 2'b10; w_result_src = 2'b10; w_pc_update = 1'b1;
            end
            S_DECODE:   begin w_src_a = 2'b01; w_src_b = 2'b01; end
            S_MEMADR:   begin w_src_a = 2'b10; w_src_b = 2'b01; end
            S_MEMREAD:  w_adr_src = 1'b1;
            S_MEMWB:    begin w_result_src = 2'b01; w_reg_write = 1'b1; end
            S_MEMWRITE: begin w_adr_src = 1'b1; w_mem_write = 1'b1; end
            S_EXECR:    begin w_src_a = 2'b10; w_src_b = 2'b00; w_alu_op = 2'b10; end
            S_EXECI:    begin w_src_a = 2'b10; w_src_b = 2'b01; w_alu_op = 2'b10; end
            S_ALUWB:    w_reg_write = 1'b1;
            S_BEQ:      begin w_src_a = 2'b10; w_alu_op = 2'b01; w_branch = 1'b1; end
            S_JAL:      begin w_src_a = 2'b01; w_src_b = 2'b10; w_pc_update = 1'b1; end
            default:    ;
        endcase
    end

    // op[5] separates R-type from I-type, so addi never turns into sub.
    always_comb begin
        w_alu_control = ALU_ADD;
        case (w_alu_op)
            2'b01: w_alu_control = ALU_SUB;
            2'b10: begin
                case (bus.funct3)
                    3'b000:  w_alu_control = (bus.op[5] & bus.funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  w_alu_control = ALU_SLT;
                    3'b110:  w_alu_control = ALU_OR;
                    3'b111:  w_alu_control = ALU_AND;
                    default: w_alu_control = ALU_ADD;
                endcase
            end
            default: w_alu_control = ALU_ADD;
        endcase
    end

    always_comb begin
        w_imm_src = 2'b00;
        case (bus.op)
            OP_SW:   w_imm_src = 2'b01;
            OP_BEQ:  w_imm_src = 2'b10;
            OP_JAL:  w_imm_src = 2'b11;
            default: w_imm_src = 2'b00;
        endcase
    end

    // Write enables are masked while reset is held so an aborted instruction commits nothing.
    assign bus.PCWrite    = ~reset & (w_pc_update | (w_branch & bus.Zero));
    assign bus.IRWrite    = ~reset & w_ir_write;
    assign bus.MemWrite   = ~reset & w_mem_write;
    assign bus.RegWrite   = ~reset & w_reg_write;
    assign bus.AdrSrc     = w_adr_src;
    assign bus.ResultSrc  = w_result_src;
    assign bus.ALUSrcA    = w_src_a;
    assign bus.ALUSrcB    = w_src_b;
    assign bus.ALUControl = w_alu_control;
    assign bus.ImmSrc     = w_imm_src;
    assign bus.state      = r_state;
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: path-based reference model checked every cycle,
// plus directed instruction traces with literal expectations.
module tb_multicycle_controller;
  logic clk = 1'b0;
  logic reset;
  int total = 0;
  int bad = 0;

  multicycle_controller_if bus();

  multicycle_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queue of upcoming states, refilled with each instruction's path.
  logic [3:0] exp_q[$];
  bit m_valid = 1'b0;

  function automatic void push_route(input logic [6:0] op);
    case (op)
      7'b0000011: begin exp_q.push_back(4'd2); exp_q.push_back(4'd3); exp_q.push_back(4'd4); end
      7'b0100011: begin exp_q.push_back(4'd2); exp_q.push_back(4'd5); end
      7'b0110011: begin exp_q.push_back(4'd6); exp_q.push_back(4'd8); end
      7'b0010011: begin exp_q.push_back(4'd7); exp_q.push_back(4'd8); end
      7'b1100011: exp_q.push_back(4'd9);
      7'b1101111: begin exp_q.push_back(4'd10); exp_q.push_back(4'd8); end
      default: ;
    endcase
  endfunction

  always @(posedge clk) begin
    logic [3:0] cur;
    if (reset) begin
      exp_q = '{4'd0};
      m_valid = 1'b1;
    end else if (m_valid) begin
      cur = exp_q.pop_front();
      if (cur == 4'd0) exp_q.push_back(4'd1);
      else if (cur == 4'd1) push_route(bus.op);
      if (exp_q.size() == 0) exp_q.push_back(4'd0);
    end
  end

  function automatic logic [2:0] model_alu(input logic [1:0] aop, input logic [6:0] op,
                                           input logic [2:0] f3, input logic f7);
    if (aop == 2'b01) return 3'b001;
    if (aop != 2'b10) return 3'b000;
    case (f3)
      3'b000:  return (op[5] && f7) ? 3'b001 : 3'b000;
      3'b010:  return 3'b101;
      3'b110:  return 3'b011;
      3'b111:  return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [1:0] model_imm(input logic [6:0] op);
    if (op == 7'b0100011) return 2'b01;
    if (op == 7'b1100011) return 2'b10;
    if (op == 7'b1101111) return 2'b11;
    return 2'b00;
  endfunction

  always @(negedge clk) begin
    logic [3:0] s;
    logic ir, adr, mw, rw, pcu, br;
    logic [1:0] rs, sa, sb, aop;
    if (m_valid) begin
      s = exp_q[0];
      {ir, adr, mw, rw, pcu, br} = '0;
      {rs, sa, sb, aop} = '0;
      case (s)
        4'd0:  begin ir = 1; sb = 2'b10; rs = 2'b10; pcu = 1; end
        4'd1:  begin sa = 2'b01; sb = 2'b01; end
        4'd2:  begin sa = 2'b10; sb = 2'b01; end
        4'd3:  adr = 1;
        4'd4:  begin rs = 2'b01; rw = 1; end
        4'd5:  begin adr = 1; mw = 1; end
        4'd6:  begin sa = 2'b10; aop = 2'b10; end
        4'd7:  begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
        4'd8:  rw = 1;
        4'd9:  begin sa = 2'b10; aop = 2'b01; br = 1; end
        4'd10: begin sa = 2'b01; sb = 2'b10; pcu = 1; end
        default: ;
      endcase
      chk("m_state", bus.state, s);
      chk("m_irwrite", bus.IRWrite, ir & ~reset);
      chk("m_memwrite", bus.MemWrite, mw & ~reset);
      chk("m_regwrite", bus.RegWrite, rw & ~reset);
      chk("m_pcwrite", bus.PCWrite, (pcu | (br & bus.Zero)) & ~reset);
      chk("m_adrsrc", bus.AdrSrc, adr);
      chk("m_resultsrc", bus.ResultSrc, rs);
      chk("m_srca", bus.ALUSrcA, sa);
      chk("m_srcb", bus.ALUSrcB, sb);
      chk("m_aluctl", bus.ALUControl, model_alu(aop, bus.op, bus.funct3, bus.funct7b5));
      chk("m_immsrc", bus.ImmSrc, model_imm(bus.op));
    end
  end

  // Per-cycle records from the latest directed instruction (bit/index i = cycle i).
  logic [7:0] rw_v, mw_v, pcw_v, irw_v;
  logic [2:0] alu_at[8];
  logic [1:0] rs_at[8];
  logic [1:0] ims_at[8];
  logic       adr_at[8];

  // Starts in FETCH at posedge+2; returns at posedge+2 of the following FETCH.
  task automatic run_instr(input string nm, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic z, input int n, input logic [23:0] tr);
    bus.op = op; bus.funct3 = f3; bus.funct7b5 = f7; bus.Zero = z;
    rw_v = '0; mw_v = '0; pcw_v = '0; irw_v = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      #1;
      chk({nm, "_state"}, bus.state, tr[4*(n-1-i) +: 4]);
      rw_v[i] = bus.RegWrite; mw_v[i] = bus.MemWrite;
      pcw_v[i] = bus.PCWrite; irw_v[i] = bus.IRWrite;
      alu_at[i] = bus.ALUControl; rs_at[i] = bus.ResultSrc;
      ims_at[i] = bus.ImmSrc; adr_at[i] = bus.AdrSrc;
    end
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset = 1'b1;
    bus.op = 7'b0; bus.funct3 = 3'b0; bus.funct7b5 = 1'b0; bus.Zero = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    @(negedge clk);
    #1;
    chk("rst_state", bus.state, 4'd0);
    chk("rst_irwrite", bus.IRWrite, 1'b0);
    chk("rst_pcwrite", bus.PCWrite, 1'b0);
    @(posedge clk);
    #2;
    reset = 1'b0;

    run_instr("lw", 7'b0000011, 3'b010, 1'b0, 1'b0, 5, 24'h001234);
    chk("first_fetch_ir", irw_v, 8'b00001);
    chk("first_fetch_pc", pcw_v, 8'b00001);
    chk("lw_regwrite", rw_v, 8'b10000);
    chk("lw_resultsrc", rs_at[4], 2'b01);
    chk("lw_memwrite", mw_v, 8'b0);

    run_instr("sw", 7'b0100011, 3'b010, 1'b0, 1'b0, 4, 24'h000125);
    chk("sw_memwrite", mw_v, 8'b1000);
    chk("sw_adrsrc", adr_at[3], 1'b1);
    chk("sw_immsrc", ims_at[0], 2'b01);
    chk("sw_regwrite", rw_v, 8'b0);

    run_instr("rsub", 7'b0110011, 3'b000, 1'b1, 1'b1, 4, 24'h000168);
    chk("rsub_alu", alu_at[2], 3'b001);
    chk("rsub_pcw_zero_ignored", pcw_v, 8'b0001);
    chk("rsub_regwrite", rw_v, 8'b1000);
    run_instr("rand", 7'b0110011, 3'b111, 1'b0, 1'b0, 4, 24'h000168);
    chk("rand_alu", alu_at[2], 3'b111);
    run_instr("rslt", 7'b0110011, 3'b010, 1'b0, 1'b0, 4, 24'h000168);
    chk("rslt_alu", alu_at[2], 3'b101);
    run_instr("ror", 7'b0110011, 3'b110, 1'b0, 1'b0, 4, 24'h000168);
    chk("ror_alu", alu_at[2], 3'b011);
    run_instr("radd", 7'b0110011, 3'b000, 1'b0, 1'b0, 4, 24'h000168);
    chk("radd_alu", alu_at[2], 3'b000);

    run_instr("addi", 7'b0010011, 3'b000, 1'b1, 1'b0, 4, 24'h000178);
    chk("addi_alu", alu_at[2], 3'b000);
    chk("addi_immsrc", ims_at[2], 2'b00);

    run_instr("beq_t", 7'b1100011, 3'b000, 1'b0, 1'b1, 3, 24'h000019);
    chk("beq_taken_pcw", pcw_v, 8'b101);
    chk("beq_alu", alu_at[2], 3'b001);
    chk("beq_immsrc", ims_at[1], 2'b10);
    run_instr("beq_n", 7'b1100011, 3'b000, 1'b0, 1'b0, 3, 24'h000019);
    chk("beq_not_taken_pcw", pcw_v, 8'b001);

    run_instr("jal", 7'b1101111, 3'b000, 1'b0, 1'b0, 4, 24'h0001a8);
    chk("jal_pcw", pcw_v, 8'b0101);
    chk("jal_regwrite", rw_v, 8'b1000);
    chk("jal_immsrc", ims_at[0], 2'b11);

    run_instr("nop", 7'b0000000, 3'b000, 1'b0, 1'b1, 2, 24'h000001);
    chk("nop_pcw", pcw_v, 8'b01);
    chk("nop_writes", rw_v | mw_v, 8'b0);
    run_instr("bad_op", 7'b1111111, 3'b000, 1'b0, 1'b0, 2, 24'h000001);
    chk("bad_op_immsrc", ims_at[1], 2'b00);

    // Abort a store in MEMWRITE by asserting reset.
    bus.op = 7'b0100011; bus.Zero = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    #1;
    chk("abort_pre_memwrite", bus.MemWrite, 1'b1);
    reset = 1'b1;
    #1;
    chk("abort_memwrite", bus.MemWrite, 1'b0);
    chk("abort_state_hold", bus.state, 4'd5);
    @(posedge clk);
    #2;
    chk("abort_state", bus.state, 4'd0);
    chk("abort_irwrite", bus.IRWrite, 1'b0);
    @(posedge clk);
    #2;
    chk("abort_irwrite2", bus.IRWrite, 1'b0);
    reset = 1'b0;
    run_instr("sw_after", 7'b0100011, 3'b010, 1'b0, 1'b0, 4, 24'h000125);
    chk("sw_after_ir", irw_v, 8'b0001);
    chk("sw_after_memwrite", mw_v, 8'b1000);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
